// File: rtl/lut6_reconfig_ctrl_if.sv
// Configuration handshake between the host sequencer and lut6_reconfig_ctrl.
// The host (master) offers a 64-bit truth table with cfg_valid.
// The controller (slave) accepts it while cfg_ready is high.
interface lut6_reconfig_ctrl_if;
  logic [63:0] cfg_data;
  logic        cfg_valid;
  logic        cfg_ready;

  modport master (
    output cfg_data,
    output cfg_valid,
    input  cfg_ready
  );

  modport slave (
    input  cfg_data,
    input  cfg_valid,
    output cfg_ready
  );
endinterface

// File: rtl/lut6_reconfig_ctrl.sv
// Hitless run-time reconfiguration controller for one 6-input LUT.
//
// A new truth table is accepted over the cfg handshake. It is then shifted
// MSB-first into a shadow table one bit per clock, which models the serial
// configuration chain. Afterwards it is committed to the active table in a
// single edge. The lookup output always reads a complete table, either the
// old one or the new one.
//
// Optional feature: define LUT6_READBACK_EN to add rb_data_o and rb_valid_o.
// At each commit, rb_data_o captures the table that was just replaced.
module lut6_reconfig_ctrl #(
  parameter logic [63:0] INIT = 64'h0000000000000000
) (
  input  logic                  clk,
  input  logic                  rst,
  lut6_reconfig_ctrl_if.slave   cfg,
  input  logic                  adr0_i,
  input  logic                  adr1_i,
  input  logic                  adr2_i,
  input  logic                  adr3_i,
  input  logic                  adr4_i,
  input  logic                  adr5_i,
  output logic                  o_o,
  output logic                  busy_o,
  output logic                  done_o
`ifdef LUT6_READBACK_EN
  ,
  output logic [63:0]           rb_data_o,
  output logic                  rb_valid_o
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  state_t      state_q;
  logic [63:0] active_q;
  logic [63:0] shadow_q;
  logic [63:0] shreg_q;
  logic [5:0]  cnt_q;
  logic [5:0]  adr;

  assign adr = {adr5_i, adr4_i, adr3_i, adr2_i, adr1_i, adr0_i};

  // Load sequencer: accept -> 64 shift cycles -> single-edge commit.
  // The encoding 2'd3 is unused and falls back to IDLE through the default branch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      active_q <= INIT;
      shadow_q <= 64'd0;
      shreg_q  <= 64'd0;
      cnt_q    <= 6'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cfg.cfg_valid) begin
            shreg_q <= cfg.cfg_data;
            cnt_q   <= 6'd0;
            state_q <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          shadow_q <= {shadow_q[62:0], shreg_q[63]};
          shreg_q  <= {shreg_q[62:0], 1'b0};
          // The count wraps 63 -> 0 on the same edge that enters COMMIT.
          cnt_q    <= cnt_q + 6'd1;
          if (cnt_q == 6'd63) begin
            state_q <= ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          active_q <= shadow_q;
          state_q  <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // The status outputs decode only the registered state, so no input reaches them combinationally.
  assign cfg.cfg_ready = (state_q == ST_IDLE);
  assign busy_o        = (state_q != ST_IDLE);
  assign done_o        = (state_q == ST_COMMIT);

  // The lookup reads only the active table, so a load that is in progress is never visible.
  assign o_o = active_q[adr];

`ifdef LUT6_READBACK_EN
  logic [63:0] rb_data_q;

  // On each commit, capture the table that is being replaced.
  always_ff @(posedge clk) begin
    if (rst) begin
      rb_data_q <= 64'd0;
    end else if (state_q == ST_COMMIT) begin
      rb_data_q <= active_q;
    end
  end

  assign rb_data_o  = rb_data_q;
  assign rb_valid_o = (state_q == ST_COMMIT);
`endif

endmodule

// File: tb/tb_lut6_reconfig_ctrl.sv
// Directed testbench for lut6_reconfig_ctrl.
// Instance A uses INIT=64'h8000000000000000.
// Instance B uses INIT=64'hAAAAAAAAAAAAAAAA and is used for the hitless sweep.
module tb_lut6_reconfig_ctrl;

  localparam logic [63:0] INIT_A = 64'h8000000000000000;
  localparam logic [63:0] INIT_B = 64'hAAAAAAAAAAAAAAAA;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  lut6_reconfig_ctrl_if ifa ();
  lut6_reconfig_ctrl_if ifb ();

  logic [5:0] adr_a = 6'd0;
  logic [5:0] adr_b = 6'd0;
  logic o_a, busy_a, done_a;
  logic o_b, busy_b, done_b;
`ifdef LUT6_READBACK_EN
  logic [63:0] rb_data_a, rb_data_b;
  logic        rb_valid_a, rb_valid_b;
`endif

  int n_cmp = 0;
  int n_err = 0;

  lut6_reconfig_ctrl #(.INIT(INIT_A)) dut_a (
    .clk(clk), .rst(rst), .cfg(ifa),
    .adr0_i(adr_a[0]), .adr1_i(adr_a[1]), .adr2_i(adr_a[2]),
    .adr3_i(adr_a[3]), .adr4_i(adr_a[4]), .adr5_i(adr_a[5]),
    .o_o(o_a), .busy_o(busy_a), .done_o(done_a)
`ifdef LUT6_READBACK_EN
    , .rb_data_o(rb_data_a), .rb_valid_o(rb_valid_a)
`endif
  );

  lut6_reconfig_ctrl #(.INIT(INIT_B)) dut_b (
    .clk(clk), .rst(rst), .cfg(ifb),
    .adr0_i(adr_b[0]), .adr1_i(adr_b[1]), .adr2_i(adr_b[2]),
    .adr3_i(adr_b[3]), .adr4_i(adr_b[4]), .adr5_i(adr_b[5]),
    .o_o(o_b), .busy_o(busy_b), .done_o(done_b)
`ifdef LUT6_READBACK_EN
    , .rb_data_o(rb_data_b), .rb_valid_o(rb_valid_b)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++; if (ifa.cfg_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", ifa.cfg_ready); end
    n_cmp++; if (busy_a !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy_a); end
    n_cmp++; if (done_a !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done_a); end
    adr_a = 6'h3F; #1;
    n_cmp++; if (o_a !== 1'b1) begin n_err++; $display("FAIL reset_o_3f: got %b want 1", o_a); end
    adr_a = 6'h3E; #1;
    n_cmp++; if (o_a !== 1'b0) begin n_err++; $display("FAIL reset_o_3e: got %b want 0", o_a); end
    adr_b = 6'h00; #1;
    n_cmp++; if (o_b !== 1'b0) begin n_err++; $display("FAIL reset_b_o_00: got %b want 0", o_b); end
    adr_b = 6'h01; #1;
    n_cmp++; if (o_b !== 1'b1) begin n_err++; $display("FAIL reset_b_o_01: got %b want 1", o_b); end
    $display("reset: A ready=%b busy=%b, B o[1]=%b", ifa.cfg_ready, busy_a, o_b);
  endtask

  task automatic test_load();
    int bad_ready;
    int bad_done;
    bad_ready = 0;
    bad_done  = 0;
    ifa.cfg_data  = 64'h0000000000000001;
    ifa.cfg_valid = 1'b1;
    tick();
    ifa.cfg_valid = 1'b0;
    for (int k = 1; k <= 65; k++) begin
      if (ifa.cfg_ready !== 1'b0 || busy_a !== 1'b1) bad_ready++;
      if (done_a !== (k == 65)) bad_done++;
      tick();
    end
    n_cmp++; if (bad_ready != 0) begin n_err++; $display("FAIL load_ready_busy: got %0d bad cycles want 0", bad_ready); end
    n_cmp++; if (bad_done != 0) begin n_err++; $display("FAIL load_done_timing: got %0d bad cycles want 0", bad_done); end
    n_cmp++; if (ifa.cfg_ready !== 1'b1 || done_a !== 1'b0) begin n_err++; $display("FAIL load_back_idle: got ready=%b done=%b want 1/0", ifa.cfg_ready, done_a); end
    adr_a = 6'h00; #1;
    n_cmp++; if (o_a !== 1'b1) begin n_err++; $display("FAIL load_o_00: got %b want 1", o_a); end
    adr_a = 6'h3F; #1;
    n_cmp++; if (o_a !== 1'b0) begin n_err++; $display("FAIL load_o_3f: got %b want 0", o_a); end
    $display("load 0x1: bad_ready=%0d bad_done=%0d", bad_ready, bad_done);
  endtask

  task automatic test_hitless();
    logic [63:0] old_t;
    logic [63:0] new_t;
    int bad_old;
    int bad_new;
    int bad_done;
    old_t    = INIT_B;
    new_t    = 64'hFFFF0000FFFF0000;
    bad_old  = 0;
    bad_new  = 0;
    bad_done = 0;
    ifb.cfg_data  = new_t;
    ifb.cfg_valid = 1'b1;
    tick();
    ifb.cfg_valid = 1'b0;
    for (int k = 1; k <= 65; k++) begin
      adr_b = 6'((k - 1) % 64);
      #1;
      if (o_b !== old_t[adr_b]) bad_old++;
      if (done_b !== (k == 65)) bad_done++;
      tick();
    end
    for (int k = 0; k < 64; k++) begin
      adr_b = 6'(k);
      #1;
      if (o_b !== new_t[adr_b]) bad_new++;
      tick();
    end
    n_cmp++; if (bad_old != 0) begin n_err++; $display("FAIL hitless_old: got %0d bad lookups want 0", bad_old); end
    n_cmp++; if (bad_new != 0) begin n_err++; $display("FAIL hitless_new: got %0d bad lookups want 0", bad_new); end
    n_cmp++; if (bad_done != 0) begin n_err++; $display("FAIL hitless_done: got %0d bad cycles want 0", bad_done); end
    $display("hitless: bad_old=%0d bad_new=%0d bad_done=%0d", bad_old, bad_new, bad_done);
  endtask

  task automatic test_back_to_back();
    logic [63:0] x_t;
    logic [63:0] y_t;
    int n_acc;
    int n_done;
    int first_done;
    int second_done;
    logic acc;
    x_t = 64'h00000000000000F0;
    y_t = 64'h0000000000000F00;
    n_acc = 0;
    n_done = 0;
    first_done = -1;
    second_done = -1;
    ifa.cfg_data  = x_t;
    ifa.cfg_valid = 1'b1;
    for (int c = 0; c < 180; c++) begin
      acc = ifa.cfg_ready & ifa.cfg_valid;
      tick();
      if (acc) begin
        n_acc++;
        if (n_acc == 1) ifa.cfg_data = y_t;
        if (n_acc == 2) ifa.cfg_valid = 1'b0;
      end
      if (done_a === 1'b1) begin
        n_done++;
        if (n_done == 1) first_done = c;
        if (n_done == 2) second_done = c;
      end
    end
    ifa.cfg_valid = 1'b0;
    n_cmp++; if (n_done != 2) begin n_err++; $display("FAIL b2b_done_count: got %0d want 2", n_done); end
    n_cmp++; if (second_done - first_done != 66) begin n_err++; $display("FAIL b2b_done_spacing: got %0d want 66", second_done - first_done); end
    n_cmp++; if (n_acc != 2) begin n_err++; $display("FAIL b2b_accepts: got %0d want 2", n_acc); end
    adr_a = 6'd8; #1;
    n_cmp++; if (o_a !== 1'b1) begin n_err++; $display("FAIL b2b_o_08: got %b want 1", o_a); end
    adr_a = 6'd4; #1;
    n_cmp++; if (o_a !== 1'b0) begin n_err++; $display("FAIL b2b_o_04: got %b want 0", o_a); end
    $display("back_to_back: accepts=%0d dones=%0d at %0d and %0d", n_acc, n_done, first_done, second_done);
  endtask

  task automatic test_reset_mid();
    int n_done;
    ifa.cfg_data  = 64'hFFFFFFFFFFFFFFFF;
    ifa.cfg_valid = 1'b1;
    tick();
    ifa.cfg_valid = 1'b0;
    for (int k = 1; k < 30; k++) tick();
    n_cmp++; if (busy_a !== 1'b1) begin n_err++; $display("FAIL mid_busy_before: got %b want 1", busy_a); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++; if (ifa.cfg_ready !== 1'b1 || busy_a !== 1'b0 || done_a !== 1'b0) begin n_err++; $display("FAIL mid_idle: got ready=%b busy=%b done=%b want 1/0/0", ifa.cfg_ready, busy_a, done_a); end
    adr_a = 6'h3F; #1;
    n_cmp++; if (o_a !== 1'b1) begin n_err++; $display("FAIL mid_o_3f: got %b want 1", o_a); end
    adr_a = 6'h3E; #1;
    n_cmp++; if (o_a !== 1'b0) begin n_err++; $display("FAIL mid_o_3e: got %b want 0", o_a); end
    n_done = 0;
    for (int k = 0; k < 70; k++) begin
      if (done_a === 1'b1) n_done++;
      tick();
    end
    n_cmp++; if (n_done != 0) begin n_err++; $display("FAIL mid_no_done: got %0d want 0", n_done); end
    n_cmp++; if (o_a !== 1'b0) begin n_err++; $display("FAIL mid_o_3e_later: got %b want 0", o_a); end
    $display("reset_mid: ready=%b busy=%b dones=%0d", ifa.cfg_ready, busy_a, n_done);
  endtask

`ifdef LUT6_READBACK_EN
  // Drives one load on instance A without checking anything.
  // Reports whether DONE appeared, whether RB_VALID matched at that cycle, and
  // finishes one cycle after DONE.
  task automatic load_a(input logic [63:0] data, output int got_done, output int rbv_bad);
    got_done = 0;
    rbv_bad  = 0;
    ifa.cfg_data  = data;
    ifa.cfg_valid = 1'b1;
    tick();
    ifa.cfg_valid = 1'b0;
    for (int k = 0; k < 100 && got_done == 0; k++) begin
      if (rb_valid_a !== done_a) rbv_bad++;
      if (done_a === 1'b1) got_done = 1;
      tick();
    end
  endtask

  task automatic test_readback();
    logic [63:0] a_t;
    int got_done;
    int rbv_bad;
    a_t = 64'h0123456789ABCDEF;
    n_cmp++; if (rb_data_a !== 64'd0 || rb_valid_a !== 1'b0) begin n_err++; $display("FAIL rb_reset: got %h/%b want 0/0", rb_data_a, rb_valid_a); end
    load_a(a_t, got_done, rbv_bad);
    n_cmp++; if (got_done != 1 || rbv_bad != 0) begin n_err++; $display("FAIL rb_first_done: got done=%0d rbv_bad=%0d want 1/0", got_done, rbv_bad); end
    n_cmp++; if (rb_data_a !== INIT_A) begin n_err++; $display("FAIL rb_data_first: got %h want %h", rb_data_a, INIT_A); end
    tick();
    load_a(~a_t, got_done, rbv_bad);
    n_cmp++; if (got_done != 1 || rbv_bad != 0) begin n_err++; $display("FAIL rb_second_done: got done=%0d rbv_bad=%0d want 1/0", got_done, rbv_bad); end
    n_cmp++; if (rb_data_a !== a_t) begin n_err++; $display("FAIL rb_data_second: got %h want %h", rb_data_a, a_t); end
    $display("readback: rb_data=%h", rb_data_a);
  endtask
`endif

  initial begin
    ifa.cfg_data  = 64'd0;
    ifa.cfg_valid = 1'b0;
    ifb.cfg_data  = 64'd0;
    ifb.cfg_valid = 1'b0;
    tick();
    test_reset();
    test_load();
    test_hitless();
    test_back_to_back();
    test_reset_mid();
`ifdef LUT6_READBACK_EN
    test_reset();
    test_readback();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
